// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit RAM plus a two-register MMIO window.
// It answers the multicycle CPU's MemRead/MemWrite strobes with registered
// read data and a one-cycle rvalid. A loader port preloads RAM, even while
// rst is held. Illegal accesses set a sticky error flag and latch the first
// offending byte address.
//
// Handshake: there is no back-pressure. A read strobe in cycle N is always
// accepted (unless rst=1), and rvalid/rdata are presented during cycle N+1.
// A write strobe in cycle N takes effect at the edge ending cycle N.
module mem_responder #(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] IO_OUT_ADDR = 32'hFFFF_FFF0,
  parameter logic [31:0] IO_IN_ADDR  = 32'hFFFF_FFF4,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [31:0]   io_in,
  output logic [31:0]   io_out,
  output logic          err,
  output logic [31:0]   err_addr,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt,
  output logic          dbg_state
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] ram [DEPTH];
  logic [31:0] rdata_q, io_out_q, err_addr_q;
  logic        err_q;
  logic [15:0] rd_cnt_q, wr_cnt_q;

  logic [AW-1:0] ram_idx;
  logic          ram_legal, is_io_out, is_io_in, both;
  logic          rd_ok, wr_ok, illegal, cpu_ram_we, io_out_we;
  logic [31:0]   rd_src;

  // Address decode. CPU strobes are ignored entirely while rst is high.
  assign ram_idx    = addr[AW+1:2];
  assign ram_legal  = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
  assign is_io_out  = (addr == IO_OUT_ADDR);
  assign is_io_in   = (addr == IO_IN_ADDR);
  assign both       = mem_read && mem_write;
  assign rd_ok      = !rst && mem_read && !mem_write && (ram_legal || is_io_out || is_io_in);
  assign wr_ok      = !rst && mem_write && !mem_read && (ram_legal || is_io_out);
  assign illegal    = !rst && (mem_read || mem_write) && !rd_ok && !wr_ok;
  assign cpu_ram_we = wr_ok && ram_legal;
  assign io_out_we  = wr_ok && is_io_out;

  // Read source mux: I/O registers take priority over the RAM word.
  always_comb begin
    rd_src = ram[ram_idx];
    if (is_io_in) begin
      rd_src = io_in;
    end else if (is_io_out) begin
      rd_src = io_out_q;
    end
  end

  // Response FSM next state: any read strobe (legal or not) produces a response.
  always_comb begin
    state_d = IDLE;
    if (mem_read && !both && rd_ok) begin
      state_d = RESP;
    end else if (mem_read && !rst) begin
      state_d = RESP;
    end
  end

  // Response FSM state register.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM write ports; the CPU write comes last so it wins a same-word collision.
  always_ff @(posedge cclk) begin
    if (load_en) begin
      ram[load_addr] <= load_data;
    end
    if (cpu_ram_we) begin
      ram[ram_idx] <= wdata;
    end
  end

  // Read data, io_out, error capture and access counters.
  always_ff @(posedge cclk) begin
    if (rst) begin
      rdata_q    <= '0;
      io_out_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (rd_ok) begin
        rdata_q  <= rd_src;
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end else if (mem_read) begin
        rdata_q  <= 32'hDEAD_BEEF;
      end
      if (wr_ok) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (io_out_we) begin
        io_out_q <= wdata;
      end
      if (illegal) begin
        err_q <= 1'b1;
        if (!err_q) begin
          err_addr_q <= addr;
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = (state_q == RESP);
  assign io_out    = io_out_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a read-data scoreboard queue.
module tb_mem_responder;

  localparam int AW = 8;

  logic          cclk = 1'b0;
  logic          rst, mem_read, mem_write, load_en;
  logic [31:0]   addr, wdata, load_data, io_in;
  logic [AW-1:0] load_addr;
  logic [31:0]   rdata, io_out, err_addr;
  logic          rvalid, err, dbg_state;
  logic [15:0]   rd_cnt, wr_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] model [256];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] exp_wr = 16'd0;

  mem_responder dut (
    .cclk(cclk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .io_in(io_in), .io_out(io_out), .err(err), .err_addr(err_addr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: remember whether a response is due, advance, then score it.
  task automatic tick();
    logic        pend;
    logic [31:0] e;
    pend = mem_read && !rst;
    @(posedge cclk);
    #1;
    chk("rvalid", {31'h0, rvalid}, {31'h0, pend});
    if (rvalid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow: got rdata %h with no expected entry", rdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
      end
    end
  endtask

  // Driver tasks; 'ok' marks an access the bench expects to be counted.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit ok);
    mem_read = 1'b1;
    addr     = a;
    exp_q.push_back(exp);
    if (ok) exp_rd++;
    tick();
    mem_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit ok);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    if (ok) exp_wr++;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_rd_cnt"}, {16'h0, rd_cnt}, {16'h0, exp_rd});
    chk({tag, "_wr_cnt"}, {16'h0, wr_cnt}, {16'h0, exp_wr});
  endtask

  initial begin
    logic [7:0]  w;
    logic [31:0] d;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; load_en = 1'b0;
    addr = '0; wdata = '0; load_data = '0; load_addr = '0; io_in = '0;

    // Reset state, with the loader preloading two words under rst.
    tick();
    tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_io_out", io_out, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, 32'h0);
    chk_cnts("rst");
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'h8C01_0004;
    tick();
    load_addr = 8'd1; load_data = 32'h1234_5678;
    tick();
    load_en = 1'b0;
    rst = 1'b0;

    // Preloaded words, back-to-back reads.
    rd(32'h0, 32'h8C01_0004, 1'b1);
    chk_cnts("first_read");
    rd(32'h4, 32'h1234_5678, 1'b1);
    tick();

    // Write then read the next cycle.
    wr(32'h40, 32'hCAFE_F00D, 1'b1);
    rd(32'h40, 32'hCAFE_F00D, 1'b1);
    chk_cnts("wr_rd");

    // Random write/read-back pairs in words 8..63.
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom_range(8, 63));
      if (w == 8'd16) w = 8'd17;
      d = $urandom;
      model[w] = d;
      wr({22'h0, w, 2'b00}, d, 1'b1);
    end
    for (int i = 8; i < 64; i++) begin
      if (model[i] !== 32'hx && i != 16) rd(i * 4, model[i], 1'b1);
    end
    chk_cnts("random");

    // MMIO output and input registers.
    wr(32'hFFFF_FFF0, 32'h0000_00A5, 1'b1);
    chk("io_out", io_out, 32'h0000_00A5);
    io_in = 32'h0000_003C;
    rd(32'hFFFF_FFF4, 32'h0000_003C, 1'b1);
    rd(32'hFFFF_FFF0, 32'h0000_00A5, 1'b1);
    chk_cnts("mmio");

    // Illegal accesses: misaligned read, out-of-range write, both strobes.
    rd(32'h6, 32'hDEAD_BEEF, 1'b0);
    chk("err_misaligned", {31'h0, err}, 32'h1);
    chk("err_addr_first", err_addr, 32'h6);
    wr(32'h1000, 32'h5555_5555, 1'b0);
    chk("err_addr_sticky", err_addr, 32'h6);
    chk_cnts("oob_write");
    wr(32'hFFFF_FFF4, 32'h7777_7777, 1'b0);
    chk("io_out_unchanged", io_out, 32'h0000_00A5);
    mem_write = 1'b1;
    rd(32'h40, 32'hDEAD_BEEF, 1'b0);
    mem_write = 1'b0;
    rd(32'h40, 32'hCAFE_F00D, 1'b1);
    chk("err_still", {31'h0, err}, 32'h1);
    chk_cnts("both_strobes");

    // Loader/CPU collision on word 5; loader alone on word 6 meanwhile.
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'hBBBB_BBBB;
    wr(32'h14, 32'hCCCC_CCCC, 1'b1);
    load_addr = 8'd6; load_data = 32'h6666_6666;
    tick();
    load_en = 1'b0;
    rd(32'h14, 32'hCCCC_CCCC, 1'b1);
    rd(32'h18, 32'h6666_6666, 1'b1);

    // Read issued together with rst: no response, everything cleared.
    rst = 1'b1; mem_read = 1'b1; addr = 32'h0;
    tick();
    mem_read = 1'b0;
    rst = 1'b0;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    chk_cnts("after_rst");
    chk("after_rst_err", {31'h0, err}, 32'h0);
    chk("after_rst_err_addr", err_addr, 32'h0);
    chk("after_rst_io_out", io_out, 32'h0);

    // RAM survives rst; then roll rd_cnt over.
    rd(32'h14, 32'hCCCC_CCCC, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      mem_read = 1'b1;
      addr     = 32'h0;
      exp_q.push_back(32'h8C01_0004);
      tick();
    end
    mem_read = 1'b0;
    chk("rd_cnt_ffff", {16'h0, rd_cnt}, 32'h0000_FFFF);
    rd(32'h4, 32'h1234_5678, 1'b1);
    chk("rd_cnt_wrap", {16'h0, rd_cnt}, 32'h0);
    tick();
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
